// File: rtl/fetch_unit_if.sv
// rtl/fetch_unit_if.sv - fetch stage bus: decode/hazard controls, instruction memory port, IF/ID outputs.
interface fetch_unit_if;
  logic        stall;
  logic        jump;
  logic [25:0] jump_index;
  logic        branch_taken;
  logic [31:0] branch_target;
  logic        if_flush;
  logic [31:0] imem_addr;
  logic [31:0] imem_data;
  logic [31:0] ifid_instr;
  logic [31:0] ifid_pc4;
  logic        ifid_valid;

  modport master (
    output stall, jump, jump_index, branch_taken, branch_target, if_flush, imem_data,
    input  imem_addr, ifid_instr, ifid_pc4, ifid_valid
  );

  modport slave (
    input  stall, jump, jump_index, branch_taken, branch_target, if_flush, imem_data,
    output imem_addr, ifid_instr, ifid_pc4, ifid_valid
  );
endinterface

// File: rtl/fetch_unit.sv
// rtl/fetch_unit.sv - PC register, next-PC select and IF/ID pipeline register.
// Optional flush/stall performance counters under macro FETCH_PERF_CNT_EN.
module fetch_unit #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst_n,
  fetch_unit_if.slave bus
`ifdef FETCH_PERF_CNT_EN
  ,
  output logic [31:0] flush_cnt,
  output logic [31:0] stall_cnt
`endif
);

  logic [31:0] r_pc;
  logic [31:0] r_ifid_instr;
  logic [31:0] r_ifid_pc4;
  logic        r_ifid_valid;

  logic [31:0] w_pc4;
  logic [31:0] w_jump_target;
  logic [31:0] w_branch_target;
  logic [31:0] w_next_pc;

  assign w_pc4           = r_pc + 32'd4;
  assign w_jump_target   = {r_ifid_pc4[31:28], bus.jump_index, 2'b00};
  assign w_branch_target = bus.branch_target & 32'hFFFF_FFFC;

  always_comb begin
    w_next_pc = w_pc4;
    if (bus.jump) begin
      w_next_pc = w_jump_target;
    end else if (bus.branch_taken) begin
      w_next_pc = w_branch_target;
    end
  end

  // Redirect and squash are independent: a flush still advances the PC.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_pc         <= RESET_PC;
      r_ifid_instr <= 32'h0000_0000;
      r_ifid_pc4   <= 32'h0000_0000;
      r_ifid_valid <= 1'b0;
    end else if (!bus.stall) begin
      r_pc <= w_next_pc;
      if (bus.if_flush) begin
        r_ifid_instr <= 32'h0000_0000;
        r_ifid_pc4   <= 32'h0000_0000;
        r_ifid_valid <= 1'b0;
      end else begin
        r_ifid_instr <= bus.imem_data;
        r_ifid_pc4   <= w_pc4;
        r_ifid_valid <= 1'b1;
      end
    end
  end

  assign bus.imem_addr  = r_pc;
  assign bus.ifid_instr = r_ifid_instr;
  assign bus.ifid_pc4   = r_ifid_pc4;
  assign bus.ifid_valid = r_ifid_valid;

`ifdef FETCH_PERF_CNT_EN
  logic [31:0] r_flush_cnt;
  logic [31:0] r_stall_cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_flush_cnt <= 32'h0000_0000;
      r_stall_cnt <= 32'h0000_0000;
    end else begin
      if (bus.stall) begin
        if (r_stall_cnt != 32'hFFFF_FFFF) r_stall_cnt <= r_stall_cnt + 32'd1;
      end else if (bus.if_flush) begin
        if (r_flush_cnt != 32'hFFFF_FFFF) r_flush_cnt <= r_flush_cnt + 32'd1;
      end
    end
  end

  assign flush_cnt = r_flush_cnt;
  assign stall_cnt = r_stall_cnt;
`endif

endmodule

// File: tb/tb_fetch_unit.sv
// tb/tb_fetch_unit.sv - scoreboard bench for fetch_unit: directed cases plus randomized control traffic.
module tb_fetch_unit;
  localparam logic [31:0] RST_PC = 32'h0000_0000;

  logic clk;
  logic rst_n;
  fetch_unit_if bus ();

`ifdef FETCH_PERF_CNT_EN
  logic [31:0] flush_cnt;
  logic [31:0] stall_cnt;
`endif

  fetch_unit #(.RESET_PC(RST_PC)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
`ifdef FETCH_PERF_CNT_EN
    ,
    .flush_cnt (flush_cnt),
    .stall_cnt (stall_cnt)
`endif
  );

  typedef struct {
    logic [31:0] pc;
    logic [31:0] instr;
    logic [31:0] pc4;
    logic        valid;
    logic [31:0] fcnt;
    logic [31:0] scnt;
  } exp_t;

  exp_t sb[$];
  int n_checks = 0;
  int n_errors = 0;

  logic [31:0] m_pc, m_instr, m_pc4, m_fcnt, m_scnt;
  logic        m_valid;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return {a[31:16] ^ a[15:0], a[15:0]} ^ 32'h1357_9BDF;
  endfunction

  assign bus.imem_data = mem_word(bus.imem_addr);

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_pc = RST_PC; m_instr = 0; m_pc4 = 0; m_valid = 0; m_fcnt = 0; m_scnt = 0;
  endtask

  // One clock of stimulus; the model applies the architectural rules for that edge.
  task automatic step(input logic s, input logic j, input logic [25:0] idx,
                      input logic b, input logic [31:0] tgt, input logic f);
    logic [31:0] nxt;
    exp_t e;
    @(negedge clk);
    bus.stall = s; bus.jump = j; bus.jump_index = idx;
    bus.branch_taken = b; bus.branch_target = tgt; bus.if_flush = f;
    if (s) begin
      if (m_scnt != 32'hFFFF_FFFF) m_scnt = m_scnt + 1;
    end else begin
      if (j)      nxt = {m_pc4[31:28], idx, 2'b00};
      else if (b) nxt = {tgt[31:2], 2'b00};
      else        nxt = m_pc + 4;
      if (f) begin
        m_instr = 0; m_pc4 = 0; m_valid = 0;
        if (m_fcnt != 32'hFFFF_FFFF) m_fcnt = m_fcnt + 1;
      end else begin
        m_instr = mem_word(m_pc); m_pc4 = m_pc + 4; m_valid = 1;
      end
      m_pc = nxt;
    end
    e.pc = m_pc; e.instr = m_instr; e.pc4 = m_pc4; e.valid = m_valid;
    e.fcnt = m_fcnt; e.scnt = m_scnt;
    sb.push_back(e);
  endtask

  task automatic check_reset_vals(input string tag);
    chk({tag, "_pc"},    bus.imem_addr, RST_PC);
    chk({tag, "_instr"}, bus.ifid_instr, 32'h0);
    chk({tag, "_pc4"},   bus.ifid_pc4, 32'h0);
    chk({tag, "_valid"}, {31'h0, bus.ifid_valid}, 32'h0);
`ifdef FETCH_PERF_CNT_EN
    chk({tag, "_fcnt"},  flush_cnt, 32'h0);
    chk({tag, "_scnt"},  stall_cnt, 32'h0);
`endif
  endtask

  // Reset dropped mid-cycle while an operation is being presented.
  task automatic async_reset(input string tag, input logic s);
    @(negedge clk);
    bus.stall = s; bus.jump = 1'b1; bus.jump_index = 26'h3FF_FFFF;
    bus.branch_taken = 1'b1; bus.branch_target = 32'h0000_0800; bus.if_flush = 1'b1;
    #2 rst_n = 1'b0;
    #1 check_reset_vals(tag);
    @(posedge clk);
    #2;
    check_reset_vals({tag, "_hold"});
    bus.stall = 0; bus.jump = 0; bus.branch_taken = 0; bus.if_flush = 0;
    rst_n = 1'b1;
    model_reset();
  endtask

  initial begin : monitor
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (sb.size() > 0) begin
        e = sb.pop_front();
        chk("imem_addr",  bus.imem_addr, e.pc);
        chk("ifid_instr", bus.ifid_instr, e.instr);
        chk("ifid_pc4",   bus.ifid_pc4, e.pc4);
        chk("ifid_valid", {31'h0, bus.ifid_valid}, {31'h0, e.valid});
`ifdef FETCH_PERF_CNT_EN
        chk("flush_cnt",  flush_cnt, e.fcnt);
        chk("stall_cnt",  stall_cnt, e.scnt);
`endif
      end
    end
  end

  initial begin : watchdog
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin : stim
    rst_n = 1'b0;
    bus.stall = 0; bus.jump = 0; bus.jump_index = 0;
    bus.branch_taken = 0; bus.branch_target = 0; bus.if_flush = 0;
    model_reset();
    #1 check_reset_vals("reset");
    @(posedge clk);
    #2 rst_n = 1'b1;

    // Sequential fetch from RESET_PC.
    repeat (4) step(0, 0, 0, 0, 0, 0);
    // Taken branch with squash, misaligned target.
    step(0, 0, 0, 0, 0, 0);
    step(0, 0, 0, 1, 32'h0000_0040, 0);
    step(0, 0, 0, 1, 32'h0000_0103, 1);
    step(0, 0, 0, 0, 0, 0);
    // Jump beats branch; jump uses ifid_pc4 upper bits.
    step(0, 0, 0, 1, 32'h9000_000C, 0);
    step(0, 0, 0, 0, 0, 0);
    step(0, 1, 26'h000_0020, 1, 32'h0000_0500, 1);
    step(0, 0, 0, 0, 0, 0);
    // Stall holds everything and ignores redirect/flush.
    repeat (3) step(1, 1, 26'h123_4567, 1, 32'h0000_0200, 1);
    step(0, 0, 0, 0, 0, 0);
    // PC wraps past the top of the address space.
    step(0, 0, 0, 1, 32'hFFFF_FFFC, 0);
    step(0, 0, 0, 0, 0, 0);
    step(0, 0, 0, 0, 0, 0);
    // Async reset during redirect and during stall.
    async_reset("arst_redirect", 1'b0);
    step(0, 0, 0, 0, 0, 0);
    step(0, 0, 0, 0, 0, 0);
    step(1, 0, 0, 0, 0, 0);
    async_reset("arst_stall", 1'b1);
    step(0, 0, 0, 0, 0, 0);

    for (int i = 0; i < 400; i++) begin
      step($urandom_range(0, 3) == 0, $urandom_range(0, 9) == 0, 26'($urandom),
           $urandom_range(0, 6) == 0, $urandom, $urandom_range(0, 4) == 0);
    end

    @(negedge clk);
    @(negedge clk);
    n_checks++;
    if (sb.size() != 0) begin
      n_errors++;
      $display("FAIL scoreboard_drain: %0d entries left, expected 0", sb.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end
endmodule
